// File: rtl/uart_rx_fifo_arbiter.sv
// Round-robin arbiter sharing the UART RX FIFO read port.
// Issues Read_Done, waits the read latency, then holds the word until acked.
module uart_rx_fifo_arbiter #(
  parameter int DATA_BITS  = 8,
  parameter int NUM_REQ    = 2,
  parameter int BIST_PORT  = 1,
  parameter int RD_LATENCY = 1,
  parameter int CNT_BITS   = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 BIST_Mode,
  input  logic                 FIFO_Empty,
  input  logic [DATA_BITS-1:0] FIFO_Data,
  output logic                 Read_Done,
  input  logic [NUM_REQ-1:0]   Req,
  output logic [NUM_REQ-1:0]   Gnt,
  output logic [DATA_BITS-1:0] Rsp_Data,
  output logic [NUM_REQ-1:0]   Rsp_Valid,
  input  logic [NUM_REQ-1:0]   Rsp_Ack,
  output logic                 Busy,
  output logic [CNT_BITS-1:0]  Rd_Count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [2:0]           lat_q, lat_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   elig;
  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;

  always_comb begin
    elig = Req;
    if (BIST_Mode) elig = Req & (NUM_REQ'(1) << BIST_PORT);
  end

  // Search above the last winner first, then wrap to the low indices.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && elig[i] && (i > int'(last_q))) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && elig[i]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    lat_d   = lat_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld && !FIFO_Empty) begin
          gnt_d   = NUM_REQ'(1) << pick_idx;
          last_d  = pick_idx;
          state_d = READ;
        end
      end
      READ: begin
        lat_d   = 3'(RD_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == 3'd0) begin
          data_d  = FIFO_Data;
          state_d = HOLD;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      HOLD: begin
        if (|(Rsp_Ack & gnt_q)) begin
          cnt_d   = cnt_q + CNT_BITS'(1);
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      gnt_q   <= '0;
      lat_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Read_Done = (state_q == READ);
  assign Gnt       = gnt_q;
  assign Rsp_Valid = (state_q == HOLD) ? gnt_q : '0;
  assign Rsp_Data  = data_q;
  assign Busy      = (state_q != IDLE);
  assign Rd_Count  = cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo_arbiter.sv
// Scoreboard bench for uart_rx_fifo_arbiter with a latency-exact FIFO model.
module tb_uart_rx_fifo_arbiter;

  localparam int DW  = 8;
  localparam int NR  = 2;
  localparam int LAT = 3;
  localparam int CW  = 16;

  logic          Clk;
  logic          Rst;
  logic          BIST_Mode;
  logic          FIFO_Empty;
  logic [DW-1:0] FIFO_Data;
  logic          Read_Done;
  logic [NR-1:0] Req;
  logic [NR-1:0] Gnt;
  logic [DW-1:0] Rsp_Data;
  logic [NR-1:0] Rsp_Valid;
  logic [NR-1:0] Rsp_Ack;
  logic          Busy;
  logic [CW-1:0] Rd_Count;

  uart_rx_fifo_arbiter #(
    .DATA_BITS (DW),
    .NUM_REQ   (NR),
    .BIST_PORT (1),
    .RD_LATENCY(LAT),
    .CNT_BITS  (CW)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .BIST_Mode (BIST_Mode),
    .FIFO_Empty(FIFO_Empty),
    .FIFO_Data (FIFO_Data),
    .Read_Done (Read_Done),
    .Req       (Req),
    .Gnt       (Gnt),
    .Rsp_Data  (Rsp_Data),
    .Rsp_Valid (Rsp_Valid),
    .Rsp_Ack   (Rsp_Ack),
    .Busy      (Busy),
    .Rd_Count  (Rd_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO model: word is visible only in the cycle RD_LATENCY after Read_Done
  logic [DW-1:0] mem [16];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            pend   = 0;
  logic [DW-1:0] pend_word = '0;
  logic          stall = 1'b0;

  always @(posedge Clk) begin
    if (Read_Done === 1'b1) begin
      pend_word <= mem[rd_ptr % 16];
      rd_ptr    <= rd_ptr + 1;
      pend      <= LAT;
    end else if (pend > 0) begin
      pend <= pend - 1;
    end
  end

  assign FIFO_Data  = (pend == 1) ? pend_word : 8'hEE;
  assign FIFO_Empty = stall || (wr_ptr == rd_ptr);

  logic          auto_ack = 1'b0;
  logic [NR-1:0] ack_man  = '0;
  assign Rsp_Ack = auto_ack ? Rsp_Valid : ack_man;

  typedef struct {
    int idx;
    int data;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic prev_rd  = 1'b0;
  logic prev_vld = 1'b0;
  int   exp_cnt  = 0;

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr++;
  endtask

  task automatic expect_rsp(input int idx, input int data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  always @(negedge Clk) begin
    if (!Rst) begin
      chk("rd_b2b", 32'(Read_Done && prev_rd), 0);
      chk("gnt_onehot", 32'($onehot0(Gnt)), 1);
      chk("vld_gnt", 32'(Rsp_Valid == '0 || Rsp_Valid == Gnt), 1);
      if (Rsp_Valid != '0 && !prev_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexp_rsp", 32'(Rsp_Valid), 0);
        end else begin
          cur = exp_q.pop_front();
          chk("rsp_port", 32'(Rsp_Valid), 1 << cur.idx);
          chk("rsp_data", 32'(Rsp_Data), cur.data);
        end
      end else if (Rsp_Valid != '0) begin
        chk("rsp_stable", 32'(Rsp_Data), cur.data);
      end
    end
    prev_rd  = (Read_Done === 1'b1);
    prev_vld = (Rsp_Valid != '0);
  end

  task automatic do_reset();
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic wait_cnt(input int n, input int max);
    int k = 0;
    while (int'(Rd_Count) != n && k < max) begin
      @(negedge Clk);
      k++;
    end
    chk("wait_cnt", 32'(Rd_Count), n);
  endtask

  task automatic wait_valid(input int max);
    int k = 0;
    while (Rsp_Valid == '0 && k < max) begin
      @(negedge Clk);
      k++;
    end
    chk("wait_vld", 32'(Rsp_Valid != '0), 1);
  endtask

  initial begin
    int bad;
    Rst = 1'b1;
    BIST_Mode = 1'b0;
    Req = '0;

    // reset and single read with exact timing
    do_reset();
    chk("rst_gnt", 32'(Gnt), 0);
    chk("rst_vld", 32'(Rsp_Valid), 0);
    chk("rst_rd", 32'(Read_Done), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_data", 32'(Rsp_Data), 0);
    chk("rst_cnt", 32'(Rd_Count), 0);
    push_word(8'hA5);
    expect_rsp(0, 'hA5);
    @(negedge Clk);
    Req = 2'b01;
    @(negedge Clk);
    chk("t1_rd", 32'(Read_Done), 1);
    chk("t1_gnt", 32'(Gnt), 1);
    chk("t1_busy", 32'(Busy), 1);
    Req = '0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge Clk);
      chk("t1_wait_vld", 32'(Rsp_Valid), 0);
      chk("t1_wait_rd", 32'(Read_Done), 0);
    end
    @(negedge Clk);
    chk("t1_vld", 32'(Rsp_Valid), 1);
    chk("t1_data", 32'(Rsp_Data), 'hA5);
    ack_man = 2'b01;
    @(negedge Clk);
    ack_man = '0;
    exp_cnt++;
    chk("t1_gnt_clr", 32'(Gnt), 0);
    chk("t1_busy_clr", 32'(Busy), 0);
    chk("t1_cnt", 32'(Rd_Count), exp_cnt);

    // round robin from reset
    do_reset();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    expect_rsp(0, 'h11);
    expect_rsp(1, 'h22);
    expect_rsp(0, 'h33);
    auto_ack = 1'b1;
    Req = 2'b11;
    exp_cnt += 3;
    wait_cnt(exp_cnt, 60);
    Req = '0;

    // empty stall
    stall = 1'b1;
    push_word(8'h5C);
    expect_rsp(1, 'h5C);
    Req = 2'b10;
    bad = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Read_Done || Busy || Gnt != '0) bad++;
    end
    chk("stall_idle", 32'(bad), 0);
    stall = 1'b0;
    @(negedge Clk);
    chk("stall_gnt", 32'(Gnt), 2);
    chk("stall_rd", 32'(Read_Done), 1);
    exp_cnt++;
    wait_cnt(exp_cnt, 20);
    Req = '0;

    // BIST mask starves requester 0
    BIST_Mode = 1'b1;
    Req = 2'b11;
    push_word(8'h61);
    push_word(8'h62);
    expect_rsp(1, 'h61);
    expect_rsp(1, 'h62);
    exp_cnt += 2;
    wait_cnt(exp_cnt, 40);
    repeat (3) @(negedge Clk);
    BIST_Mode = 1'b0;
    push_word(8'h63);
    expect_rsp(0, 'h63);
    exp_cnt++;
    wait_cnt(exp_cnt, 20);
    Req = '0;

    // delayed ack, dropped request, wrong-port ack
    auto_ack = 1'b0;
    push_word(8'h77);
    push_word(8'h78);
    expect_rsp(0, 'h77);
    Req = 2'b01;
    wait_valid(20);
    Req = '0;
    bad = 0;
    repeat (5) begin
      @(negedge Clk);
      if (Rsp_Valid != 2'b01 || Rsp_Data != 8'h77 || Read_Done) bad++;
    end
    chk("hold_stable", 32'(bad), 0);
    ack_man = 2'b10;
    @(negedge Clk);
    chk("bad_ack", 32'(Rsp_Valid), 1);
    ack_man = 2'b01;
    @(negedge Clk);
    ack_man = '0;
    exp_cnt++;
    chk("ack_busy", 32'(Busy), 0);
    chk("ack_cnt", 32'(Rd_Count), exp_cnt);
    repeat (3) @(negedge Clk);
    chk("no_rearb", 32'(Busy), 0);

    // reset on the second WAIT cycle
    Req = 2'b10;
    @(negedge Clk);
    chk("t6_gnt", 32'(Gnt), 2);
    chk("t6_rd", 32'(Read_Done), 1);
    Req = '0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    exp_cnt = 0;
    chk("t6_gnt0", 32'(Gnt), 0);
    chk("t6_vld0", 32'(Rsp_Valid), 0);
    chk("t6_busy0", 32'(Busy), 0);
    chk("t6_cnt0", 32'(Rd_Count), 0);
    chk("t6_data0", 32'(Rsp_Data), 0);
    bad = 0;
    repeat (6) begin
      @(negedge Clk);
      if (Rsp_Valid != '0) bad++;
    end
    chk("t6_no_vld", 32'(bad), 0);
    push_word(8'h99);
    expect_rsp(0, 'h99);
    auto_ack = 1'b1;
    Req = 2'b11;
    exp_cnt++;
    wait_cnt(exp_cnt, 20);
    Req = '0;

    repeat (3) @(negedge Clk);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
